mac_cfg_master: RTL

MAC_CFG_MASTER -- requirements
Module: mac_cfg_master

---
 rtl/mac_cfg_master_if.sv | 26 ++
 rtl/mac_cfg_master.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mac_cfg_master_if.sv
// Peripheral bus between the config master and the accelerator's register port.
// Request/grant address phase plus an ID-tagged read response channel.
interface mac_cfg_master_if #(
  parameter int ID_WIDTH = 10
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/mac_cfg_master.sv
// Job launcher: acquires the accelerator, writes job registers, triggers it and waits for its event.
// One request outstanding at a time; request fields held stable until granted.
module mac_cfg_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          N_JOB_REGS = 5,
  parameter logic [31:0] JOB_OFFS   = 32'h40,
  parameter int          RETRY_GAP  = 4,
  parameter int          TIMEOUT    = 65535,
  parameter int          ID_WIDTH   = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [N_JOB_REGS-1:0][31:0] job_regs_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [7:0]                  job_id_o,
  input  logic                        evt_i,
  mac_cfg_master_if.master            periph
);

  localparam int IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;

  typedef enum logic [2:0] {
    IDLE, ACQ_REQ, ACQ_RESP, ACQ_WAIT, WR_PARAM, TRIG, WAIT_EVT, DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [N_JOB_REGS-1:0][31:0] regs_q, regs_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        flag_q, flag_d;
  logic                        err_q, err_d;
  logic [7:0]                  job_id_q, job_id_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      regs_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      job_id_q <= '0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      job_id_q <= job_id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    err_d    = err_q;
    job_id_d = job_id_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          regs_d  = job_regs_i;
          flag_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ACQ_REQ;
        end
      end
      ACQ_REQ: begin
        if (periph.gnt) state_d = ACQ_RESP;
      end
      ACQ_RESP: begin
        if (periph.r_valid) begin
          if (periph.r_data[31]) begin
            cnt_d   = '0;
            state_d = ACQ_WAIT;
          end else begin
            job_id_d = periph.r_data[7:0];
            idx_d    = '0;
            state_d  = WR_PARAM;
          end
        end
      end
      ACQ_WAIT: begin
        if (cnt_q == 16'(RETRY_GAP - 1)) state_d = ACQ_REQ;
        else                             cnt_d   = cnt_q + 16'd1;
      end
      WR_PARAM: begin
        if (periph.gnt) begin
          if (idx_q == IDX_W'(N_JOB_REGS - 1)) state_d = TRIG;
          else                                 idx_d   = idx_q + IDX_W'(1);
        end
      end
      TRIG: begin
        if (periph.gnt) begin
          cnt_d   = '0;
          state_d = WAIT_EVT;
          // an event in the grant cycle itself must survive into WAIT_EVT
          if (evt_i) flag_d = 1'b1;
        end
      end
      WAIT_EVT: begin
        cnt_d = cnt_q + 16'd1;
        if (flag_q || evt_i) begin
          flag_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_d == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // bus fields are pure functions of state so they cannot move while req waits for gnt
  always_comb begin
    periph.req  = 1'b0;
    periph.add  = '0;
    periph.wen  = 1'b1;
    periph.data = '0;
    case (state_q)
      ACQ_REQ: begin
        periph.req = 1'b1;
        periph.add = BASE_ADDR + 32'h4;
      end
      WR_PARAM: begin
        periph.req  = 1'b1;
        periph.wen  = 1'b0;
        periph.add  = BASE_ADDR + JOB_OFFS + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
        periph.data = regs_q[idx_q];
      end
      TRIG: begin
        periph.req = 1'b1;
        periph.wen = 1'b0;
        periph.add = BASE_ADDR;
      end
      default: ;
    endcase
  end

  assign periph.be = 4'hF;
  assign periph.id = {ID_WIDTH{1'b0}};

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign error_o  = (state_q == DONE) && err_q;
  assign job_id_o = job_id_q;

  logic unused_rsp;
  assign unused_rsp = ^{periph.r_id, periph.r_data[30:8]};

endmodule
